// File: rtl/hex_ascii_to_bin.sv
// ASCII hex character stream to binary word assembler.
// First character accepted is the most-significant nibble.
module hex_ascii_to_bin #(
   parameter  int NDIGITS = 8,
   parameter  int WIDTH   = 4 * NDIGITS,
   localparam int CW      = $clog2(NDIGITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       char_in,
   input  logic             char_valid,
   output logic             char_ready,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             err,
   output logic [CW-1:0]    digit_cnt
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] word_n;
   logic [CW-1:0]    cnt_n;
   logic             err_n;
   logic             hex_ok;
   logic [3:0]       nib;
   logic             accept;
   logic             last_digit;

   always_comb begin
      hex_ok = 1'b1;
      nib    = 4'h0;
      unique case (1'b1)
         (char_in >= 8'h30 && char_in <= 8'h39): nib = 4'(char_in - 8'h30);
         (char_in >= 8'h41 && char_in <= 8'h46): nib = 4'(char_in - 8'h37);
         (char_in >= 8'h61 && char_in <= 8'h66): nib = 4'(char_in - 8'h57);
         default:                                 hex_ok = 1'b0;
      endcase
   end

   assign char_ready = (state == ACCUM);
   assign word_valid = (state == HOLD);
   assign accept     = char_valid & char_ready;
   assign last_digit = (digit_cnt == CW'(NDIGITS - 1));

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      word_n  = word_out;
      cnt_n   = digit_cnt;
      err_n   = 1'b0;
      unique case (state)
         ACCUM: begin
            if (accept && hex_ok) begin
               // shift-or form works down to NDIGITS=1
               shreg_n = (shreg << 4) | WIDTH'(nib);
               if (last_digit) begin
                  word_n  = shreg_n;
                  cnt_n   = '0;
                  state_n = HOLD;
               end else begin
                  cnt_n = digit_cnt + CW'(1);
               end
            end else if (accept) begin
               err_n   = 1'b1;
               shreg_n = '0;
               cnt_n   = '0;
            end
         end
         HOLD: begin
            if (word_ready)
               state_n = ACCUM;
         end
         default: state_n = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ACCUM;
         shreg     <= '0;
         word_out  <= '0;
         digit_cnt <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         word_out  <= word_n;
         digit_cnt <= cnt_n;
         err       <= err_n;
      end
   end

endmodule

// File: tb/tb_hex_ascii_to_bin.sv
// Bench for hex_ascii_to_bin: directed cases plus a random
// encode/decode round trip, words checked through a scoreboard.
module tb_hex_ascii_to_bin;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  char_in = 8'h00;
   logic        char_valid = 1'b0;
   logic        char_ready;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic        err;
   logic [3:0]  digit_cnt;

   int n_vec = 0;
   int n_bad = 0;
   int err_seen = 0;
   bit rand_rdy = 1'b0;
   bit fixed_rdy = 1'b1;
   logic [31:0] sb_q[$];

   hex_ascii_to_bin #(.NDIGITS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .char_in(char_in), .char_valid(char_valid),
      .char_ready(char_ready),
      .word_out(word_out), .word_valid(word_valid),
      .word_ready(word_ready),
      .err(err), .digit_cnt(digit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // word_ready applied at edge+2 so main-thread edits land this cycle
   initial forever begin
      @(posedge clk);
      #2;
      word_ready = rand_rdy ? 1'($urandom) : fixed_rdy;
   end

   initial forever begin
      @(negedge clk);
      if (err) err_seen++;
      if (rst_n && word_valid && word_ready) begin
         if (sb_q.size() == 0)
            chk("sb_nonempty", sb_q.size(), 1);
         else
            chk("word", word_out, sb_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      int n = 0;
      bit acc;
      char_in = c;
      char_valid = 1'b1;
      forever begin
         acc = char_ready;
         tick();
         if (acc) break;
         n++;
         if (n > 200) begin
            chk("send_timeout", n, 0);
            break;
         end
      end
      char_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++)
         send(s[i]);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain", sb_q.size(), 0);
   endtask

   function automatic logic [7:0] enc(input logic [3:0] v,
                                      input bit lower);
      if (v < 4'd10) return 8'h30 + 8'(v);
      return (lower ? 8'h61 : 8'h41) + 8'(v) - 8'd10;
   endfunction

   initial begin
      string bad;
      int err0;
      logic [31:0] v;
      bit lc;

      // reset
      tick();
      tick();
      chk("rst_wvalid", word_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", digit_cnt, 0);
      chk("rst_word", word_out, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_cready", char_ready, 1);

      // 1: DEADBEEF, one-cycle word_valid after last digit
      sb_q.push_back(32'hDEADBEEF);
      send("D");
      chk("cnt_1", digit_cnt, 1);
      send_str("EADBEE");
      chk("cnt_7", digit_cnt, 7);
      send("F");
      chk("t1_wvalid", word_valid, 1);
      chk("t1_cnt0", digit_cnt, 0);
      chk("t1_cready", char_ready, 0);
      tick();
      chk("t1_wvalid_off", word_valid, 0);
      chk("t1_cready_on", char_ready, 1);
      drain();

      // 2: lowercase, then 10 chars spanning two words
      sb_q.push_back(32'hDEADBEEF);
      send_str("deadbeef");
      sb_q.push_back(32'h01234567);
      sb_q.push_back(32'h89ABCDEF);
      send_str("0123456789");
      chk("t2_cnt2", digit_cnt, 2);
      send_str("abcdef");
      drain();

      // 3: invalid character clears the partial word
      send_str("12G");
      chk("t3_err", err, 1);
      chk("t3_cnt", digit_cnt, 0);
      send("4");
      chk("t3_err_off", err, 0);
      chk("t3_cnt1", digit_cnt, 1);
      bad = "/:@G`g";
      for (int i = 0; i < bad.len(); i++) begin
         send("5");
         send(bad[i]);
         chk({"bnd_err_", bad.substr(i, i)}, err, 1);
         chk({"bnd_cnt_", bad.substr(i, i)}, digit_cnt, 0);
         tick();
         chk({"bnd_off_", bad.substr(i, i)}, err, 0);
      end
      sb_q.push_back(32'h00C0FFEE);
      send_str("00C0FFEE");
      chk("t3_noerr", err, 0);
      drain();

      // 4: backpressure
      fixed_rdy = 1'b0;
      tick();
      sb_q.push_back(32'hCAFEBABE);
      send_str("CAFEBABE");
      for (int i = 0; i < 10; i++) begin
         chk("bp_cready", char_ready, 0);
         chk("bp_wvalid", word_valid, 1);
         chk("bp_word", word_out, 32'hCAFEBABE);
         chk("bp_err", err, 0);
         char_in = "7";
         char_valid = 1'b1;
         tick();
      end
      char_valid = 1'b0;
      fixed_rdy = 1'b1;
      chk("bp_still_hold", word_valid, 1);
      tick();
      chk("bp_released", word_valid, 0);
      chk("bp_cready_on", char_ready, 1);
      chk("bp_cnt", digit_cnt, 0);
      drain();

      // 5: reset mid-word, then reset in HOLD
      send_str("ABC");
      chk("t5_cnt3", digit_cnt, 3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_cnt_rst", digit_cnt, 0);
      chk("t5_cready", char_ready, 1);
      sb_q.push_back(32'h00000001);
      send_str("00000001");
      drain();
      fixed_rdy = 1'b0;
      tick();
      send_str("11111111");
      chk("t5_hold", word_valid, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_hold_rst", word_valid, 0);
      chk("t5_word_rst", word_out, 0);
      fixed_rdy = 1'b1;
      tick();

      // 6: random round trip
      err0 = err_seen;
      rand_rdy = 1'b1;
      for (int w = 0; w < 1000; w++) begin
         v = $urandom;
         lc = 1'($urandom);
         sb_q.push_back(v);
         for (int d = 7; d >= 0; d--) begin
            if ($urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 3)) tick();
            send(enc(v[4*d +: 4], lc));
         end
      end
      drain();
      rand_rdy = 1'b0;
      chk("rt_err", err_seen - err0, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
